// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: bexkat1 front-end prefetcher with a credit-limited word FIFO and 32/64-bit assembly.
// Optional misaligned-redirect fault reporting is enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_prefetch #(
    parameter int          DEPTH_LOG2      = 3,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic [31:0] bus_adr_o,
    input  logic        bus_stall_i,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_dat_i,
    input  logic        pc_set_i,
    input  logic [31:0] pc_in_i,
    input  logic        stall_i,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o,
    output logic        ir_valid_o,
    output logic        fault_o
);
    localparam int            DEPTH     = 1 << DEPTH_LOG2;
    localparam int            CW        = DEPTH_LOG2 + 2;
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic {S_RESET, S_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]           r_fifo [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd, r_wr, w_rd1;
    logic [DEPTH_LOG2:0]   r_count, w_count_nxt;
    logic [CW-1:0]         r_out, w_inflight;
    logic [15:0]           r_drain;
    logic [31:0]           r_adr, r_npc, r_pc;
    logic [63:0]           r_ir;
    logic                  r_valid, r_fault;
    logic                  w_stb, w_accept, w_push, w_bad;
    logic [31:0]           w_head, w_second, w_target;
    logic [1:0]            w_pop;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_bad;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_bad <= 1'b0;
        else if (pc_set_i) r_bad <= (pc_in_i[1:0] != 2'b00);
    end
    assign w_bad    = r_bad;
    assign w_target = pc_in_i;
`else
    assign w_bad    = 1'b0;
    assign w_target = pc_in_i & 32'hFFFF_FFFC;
`endif

    assign w_rd1      = r_rd + 1'b1;
    assign w_head     = r_fifo[r_rd];
    assign w_second   = r_fifo[w_rd1];
    assign w_inflight = r_out + CW'(r_count);
    assign w_accept   = w_stb && !bus_stall_i;
    // Acks owed to requests from before a redirect are swallowed here, never queued.
    assign w_push     = bus_ack_i && (r_drain == 16'd0) && !pc_set_i;

    assign bus_stb_o  = w_stb;
    assign bus_adr_o  = r_adr;
    assign bus_cyc_o  = w_stb || (r_out != '0) || (r_drain != 16'd0);
    assign ir_o       = r_ir;
    assign pc_o       = r_pc;
    assign ir_valid_o = r_valid;
    assign fault_o    = r_fault;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_RESET;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stb       = 1'b0;
        case (r_state)
            S_RESET: w_state_nxt = S_RUN;
            S_RUN:   w_stb = !w_bad && (r_out < MAX_OUT_C) && (w_inflight < DEPTH_C);
            default: w_state_nxt = S_RESET;
        endcase
        if (pc_set_i) begin
            w_state_nxt = S_RESET;
            w_stb       = 1'b0;
        end
    end

    always_comb begin
        w_pop = 2'd0;
        if (!pc_set_i && !stall_i && !w_bad) begin
            if (w_head[0] && (r_count[DEPTH_LOG2:1] != '0)) w_pop = 2'd2;
            else if (!w_head[0] && (r_count != '0))         w_pop = 2'd1;
        end
    end

    assign w_count_nxt = r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr] <= bus_dat_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_drain <= 16'd0;
            r_adr   <= RESET_PC;
            r_npc   <= RESET_PC;
            r_pc    <= RESET_PC;
            r_ir    <= 64'h0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (pc_set_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out   <= '0;
            // Whatever is still in flight, less an ack landing now, becomes stale.
            r_drain <= r_drain + 16'(r_out) - 16'(bus_ack_i);
            r_adr   <= {w_target[31:2], 2'b00};
            r_npc   <= w_target;
            r_pc    <= w_target;
            r_ir    <= 64'h0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) r_adr <= r_adr + 32'd4;
            if (bus_ack_i && (r_drain != 16'd0)) r_drain <= r_drain - 16'd1;
            if (w_push) r_wr <= r_wr + 1'b1;
            r_out   <= r_out + CW'(w_accept) - CW'(w_push);
            r_rd    <= r_rd + DEPTH_LOG2'(w_pop);
            r_count <= w_count_nxt;
            if (!stall_i) begin
                if (w_bad) begin
                    r_ir    <= 64'h0;
                    r_valid <= 1'b1;
                    r_fault <= 1'b1;
                end else if (w_pop == 2'd2) begin
                    r_ir    <= {w_second, w_head};
                    r_valid <= 1'b1;
                    r_pc    <= r_npc;
                    r_npc   <= r_npc + 32'd8;
                end else if (w_pop == 2'd1) begin
                    r_ir    <= {32'h0, w_head};
                    r_valid <= 1'b1;
                    r_pc    <= r_npc;
                    r_npc   <= r_npc + 32'd4;
                end else begin
                    r_ir    <= 64'h0;
                    r_valid <= 1'b0;
                    r_pc    <= r_npc;
                end
            end
        end
    end
endmodule
